seq_packer: RTL and testbench
=============================

# seq_packer

Downstream consumer of the nucleotide generator. It collects a run of 2-bit nucleotide codes into a sequence of programmed length and packs them 16 bases per 32-bit word. Packed words are buffered in a small FIFO and emitted on a valid/ready stream for the sequence writer. It also provides per-sequence busy and done status.

## Interface
- SEQ_LEN_W, 16, width of the sequence-length input
- FIFO_DEPTH, 4, output FIFO depth in words (power of two, ≥2)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; begins a sequence; sampled only in IDLE
- seq_len  input  SEQ_LEN_W  number of bases in the sequence; sampled with start
- nt_in  input  2  nucleotide code, A=00 C=01 G=10 T=11
- nt_valid  input  1  nt_in is valid this cycle
- nt_ready  output  1  block accepts nt_in this cycle
- word_data  output  32  packed word, first base in [1:0]
- word_bases  output  5  number of valid bases in word_data, 1..16
- word_last  output  1  word is the final word of the sequence
- word_valid  output  1  FIFO head valid
- word_ready  input  1  consumer accepts the head word
- busy  output  1  a sequence is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse when the last word is accepted downstream

## Operation
- FSM states:
  - IDLE: start with seq_len≠0 → COLLECT; latch remaining=seq_len, slot=0, pack register=0. start with seq_len=0 is ignored.
  - COLLECT: a base is accepted when nt_valid && nt_ready. nt_ready = (state==COLLECT) && !fifo_full.
    - Accepted base is written at bits [2*slot+1 : 2*slot]; slot increments and remaining decrements.
    - On slot==15 or remaining==1, the completed word (including this base) is pushed to the FIFO in the same cycle. Unused upper bits are 0; word_bases=slot+1; word_last=(remaining==1).
    - After a push, the pack register and slot clear to 0.
    - Accepting the final base → DRAIN.
  - DRAIN: nt_ready=0. The cycle in which the word_last word handshakes (word_valid && word_ready) pulses done → IDLE.
- FIFO pop on word_valid && word_ready; word_valid = !fifo_empty.
- Push and pop may occur in the same cycle when the FIFO is not full; occupancy is unchanged.
- When full, no push occurs even if a pop happens that cycle: nt_ready uses the registered full flag only.
- start while busy: ignored, seq_len not re-sampled.
- nt_valid while nt_ready=0: ignored; nt_in is not consumed.
- remaining counter is SEQ_LEN_W bits and does not wrap; it reaches 0 only on the final base.

## Timing
- Reset values: nt_ready=0, word_valid=0, word_data=0, word_bases=0, word_last=0, busy=0, done=0. FSM goes to IDLE, FIFO is emptied, counters and pack register are 0.
- Reset mid-operation aborts the sequence; partial words and queued words are discarded. No done pulse.
- start at cycle N → busy=1 and nt_ready=1 (FIFO not full) at N+1.
- Word-completing base accepted at cycle N with FIFO empty → word_valid=1 at N+1.
- Last-word handshake at cycle M → done=1 and busy=0 at M+1, for one cycle.
- Sustained throughput: one base per cycle while word_ready keeps the FIFO from filling.

## Structure
- Package seq_pkg holds:
  - nucleotide codes NT_A/NT_C/NT_G/NT_T (shared with the generator)
  - BASES_PER_WORD=16
  - the FSM state encoding IDLE/COLLECT/DRAIN
- Sub-module seq_word_fifo: synchronous FIFO, 38-bit entries {last, bases[4:0], data[31:0]}, with full/empty flags registered from its pointers.

## Test plan
- seq_len=16, bases A,C,G,T repeated, word_ready=1 → one word 0xE4E4E4E4, word_bases=16, word_last=1; done one cycle after the handshake.
- seq_len=5, all T → word 0x000003FF, word_bases=5, word_last=1; nt_ready=0 after the 5th base.
- seq_len=80, word_ready=0 → nt_ready drops after base 64 (FIFO holds 4 words). Then raise word_ready → 5 words in order, last only on the 5th, done once.
- start with seq_len=0 → busy stays 0, nt_ready stays 0, no words.
- reset asserted after 7 bases of a seq_len=20 run → next cycle all outputs at reset values. A following seq_len=2 run (C,G) yields 0x00000009, word_bases=2.
- start pulse mid-COLLECT with a different seq_len → ignored; the original length completes. nt_valid held during DRAIN → no extra bases consumed.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the nucleotide sequence path: base codes, packing
// geometry, packer FSM encoding and the packed-word FIFO entry layout.
package seq_pkg;

    // Two-bit nucleotide codes, identical to the generator's encoding.
    localparam logic [1:0] NT_A = 2'b00;
    localparam logic [1:0] NT_C = 2'b01;
    localparam logic [1:0] NT_G = 2'b10;
    localparam logic [1:0] NT_T = 2'b11;

    // Packing geometry: sixteen 2-bit bases fill one 32-bit word.
    localparam int BASES_PER_WORD = 16;
    localparam int WORD_W         = 32;
    localparam int SLOT_W         = 4;   // indexes a base slot inside a word
    localparam int BASES_W        = 5;   // holds 1..16

    // Packer control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // One FIFO entry: {last, bases, data} = 38 bits.
    typedef struct packed {
        logic               last;
        logic [BASES_W-1:0] bases;
        logic [WORD_W-1:0]  data;
    } word_entry_t;

    // Place a base into its 2-bit slot of a partially packed word.
    function automatic logic [WORD_W-1:0] insert_base(
        input logic [WORD_W-1:0] word,
        input logic [SLOT_W-1:0] slot,
        input logic [1:0]        nt
    );
        logic [WORD_W-1:0] result;
        result = word;
        result[{slot, 1'b0} +: 2] = nt;
        return result;
    endfunction

endpackage

// File: rtl/seq_word_fifo.sv
// Small synchronous FIFO of packed words. Full and empty are registers
// derived from the next-state pointers, so downstream flow control never
// sees a combinational path from push/pop.
module seq_word_fifo
    import seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  word_entry_t push_entry,
    input  logic        pop,
    output word_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    word_entry_t mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_next;
    logic [AW:0] rd_ptr_next;
    logic        do_push;
    logic        do_pop;

    // A push into a full FIFO or a pop from an empty one is dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer values for this cycle's accepted push and pop.
    always_comb begin
        // NOTE: defaults come first so every path assigns every output; a
        // missing branch assignment in always_comb would infer a latch.
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (do_push) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
        end
    end

    // Pointer and flag registers; flags are computed from the next pointers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs before any of them update.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
            empty  <= (wr_ptr_next == rd_ptr_next);
        end
    end

    // Entry storage written on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // define which entries are live, and resetting a RAM costs a clear
        // port for no behavioural gain.
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // Head is forced to zero while empty so stale storage never shows.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/seq_packer.sv
// Collects a programmed-length run of 2-bit nucleotide codes, packs them
// sixteen per 32-bit word (first base in bits [1:0]) and streams the words
// out through a small FIFO with busy/done sequence status.
module seq_packer
    import seq_pkg::*;
#(
    parameter int SEQ_LEN_W  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEQ_LEN_W-1:0] seq_len,
    input  logic [1:0]           nt_in,
    input  logic                 nt_valid,
    output logic                 nt_ready,
    output logic [WORD_W-1:0]    word_data,
    output logic [BASES_W-1:0]   word_bases,
    output logic                 word_last,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [SEQ_LEN_W-1:0] LEN_ONE   = SEQ_LEN_W'(1);
    localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(BASES_PER_WORD - 1);

    state_t               state;
    logic [SEQ_LEN_W-1:0] remaining;   // bases still to accept, including the current one
    logic [SLOT_W-1:0]    slot;        // next free base slot in the pack register
    logic [WORD_W-1:0]    pack;        // word being assembled

    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        final_base;
    logic        word_end;
    logic        push;
    logic        pop;
    logic [WORD_W-1:0] merged;
    word_entry_t push_entry;
    word_entry_t head;

    // Intake handshake: only while collecting, gated by the registered full flag.
    assign nt_ready   = (state == COLLECT) && !fifo_full;
    assign accept     = nt_valid && nt_ready;

    // A word closes when its last slot fills or the sequence runs out.
    assign final_base = (remaining == LEN_ONE);
    assign word_end   = (slot == LAST_SLOT) || final_base;
    assign push       = accept && word_end;

    // The completed word includes the base accepted this cycle.
    assign merged     = insert_base(pack, slot, nt_in);

    assign push_entry.last  = final_base;
    assign push_entry.bases = {1'b0, slot} + 5'd1;
    assign push_entry.data  = merged;

    // Output stream is the FIFO head.
    assign pop        = word_valid && word_ready;
    assign word_valid = !fifo_empty;
    assign word_data  = head.data;
    assign word_bases = head.bases;
    assign word_last  = head.last;

    assign busy = (state != IDLE);

    // Sequence control: length capture, base packing and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            slot      <= '0;
            pack      <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A zero-length request would never finish, so it is dropped.
                    if (start && (seq_len != '0)) begin
                        state     <= COLLECT;
                        remaining <= seq_len;
                        slot      <= '0;
                        pack      <= '0;
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        remaining <= remaining - LEN_ONE;
                        if (word_end) begin
                            slot <= '0;
                            pack <= '0;
                        end else begin
                            slot <= slot + 4'd1;
                            pack <= merged;
                        end
                        if (final_base) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The sequence ends when its final word leaves the FIFO.
                    if (pop && head.last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    seq_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_seq_packer.sv
// Bench for seq_packer: directed table of sequences with known packed words,
// hand-written reset/zero-length/stall/restart sequences, and randomized
// runs checked against an arithmetic packing and occupancy model.
module tb_seq_packer;

    localparam int SEQ_LEN_W  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int BPW        = 16;
    localparam int RUN_BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [SEQ_LEN_W-1:0] seq_len;
    logic [1:0]           nt_in;
    logic                 nt_valid;
    logic                 nt_ready;
    logic [31:0]          word_data;
    logic [4:0]           word_bases;
    logic                 word_last;
    logic                 word_valid;
    logic                 word_ready;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    seq_packer #(
        .SEQ_LEN_W  (SEQ_LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seq_len    (seq_len),
        .nt_in      (nt_in),
        .nt_valid   (nt_valid),
        .nt_ready   (nt_ready),
        .word_data  (word_data),
        .word_bases (word_bases),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  bases;
        logic        last;
    } word_t;

    typedef struct {
        int          len;
        int          pattern;   // 0 random, 1 A,C,G,T repeating, 2 all T, 3 C,G
        logic [31:0] w0;
        logic [4:0]  b0;
        int          nwords;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    logic [1:0] bases_q[$];
    word_t exp_q[$];
    word_t got_q[$];
    vec_t  vecs[5];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fill_bases(input int len, input int pattern);
        bases_q.delete();
        for (int i = 0; i < len; i++) begin
            case (pattern)
                1:       bases_q.push_back(2'(i % 4));
                2:       bases_q.push_back(2'b11);
                3:       bases_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
                default: bases_q.push_back(2'($urandom_range(0, 3)));
            endcase
        end
    endtask

    // Expected words straight from the packing rule: base i lands in word
    // i/16 at bit 2*(i%16); the final word carries the remainder count.
    task automatic build_expected(input int len);
        int nwords;
        exp_q.delete();
        nwords = (len + BPW - 1) / BPW;
        for (int w = 0; w < nwords; w++) begin
            word_t e;
            int    n;
            n = (len - w * BPW < BPW) ? (len - w * BPW) : BPW;
            e.data = '0;
            for (int k = 0; k < n; k++) begin
                e.data = e.data | (32'(bases_q[w * BPW + k]) << (2 * k));
            end
            e.bases = 5'(n);
            e.last  = (w == nwords - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_nt_ready"},   32'(nt_ready),   0);
        check({tag, "_word_valid"}, 32'(word_valid), 0);
        check({tag, "_word_data"},  word_data,       0);
        check({tag, "_word_bases"}, 32'(word_bases), 0);
        check({tag, "_word_last"},  32'(word_last),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_done"},       32'(done),       0);
    endtask

    // Drive one full sequence from bases_q, checking every cycle against the
    // occupancy model and every popped word against exp_q.
    task automatic run_seq(input int len, input int valid_pct, input int ready_pct,
                           input int hold, input bit mid_start);
        int idx    = 0;
        int popped = 0;
        int cyc    = 0;
        int pushed;
        int occ;
        int nwords;
        int stall_exp;
        bit fin    = 0;

        build_expected(len);
        got_q.delete();
        nwords    = exp_q.size();
        stall_exp = (len < FIFO_DEPTH * BPW) ? len : FIFO_DEPTH * BPW;

        @(negedge clk);
        start      = 1'b1;
        seq_len    = SEQ_LEN_W'(len);
        nt_valid   = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);

        while (!fin) begin
            pushed = idx / BPW + (((idx == len) && (idx % BPW != 0)) ? 1 : 0);
            occ    = pushed - popped;
            check("nt_ready",   32'(nt_ready),   32'((idx < len) && (occ < FIFO_DEPTH)));
            check("word_valid", 32'(word_valid), 32'(occ > 0));
            check("busy",       32'(busy),       1);
            check("done_quiet", 32'(done),       0);
            if (hold > 0 && cyc == hold) begin
                check("stall_accept", 32'(idx), 32'(stall_exp));
            end

            start      = mid_start && (cyc == 3);
            seq_len    = (mid_start && cyc == 3) ? SEQ_LEN_W'(len + 5) : SEQ_LEN_W'(len);
            nt_valid   = ($urandom_range(1, 100) <= valid_pct);
            nt_in      = (idx < len) ? bases_q[idx] : 2'($urandom_range(0, 3));
            word_ready = (cyc >= hold) && ($urandom_range(1, 100) <= ready_pct);

            if (nt_valid && nt_ready) begin
                idx++;
            end
            if (word_valid && word_ready) begin
                word_t g;
                g.data  = word_data;
                g.bases = word_bases;
                g.last  = word_last;
                got_q.push_back(g);
                if (popped < nwords) begin
                    check("word_data",  g.data,         exp_q[popped].data);
                    check("word_bases", 32'(g.bases),   32'(exp_q[popped].bases));
                    check("word_last",  32'(g.last),    32'(exp_q[popped].last));
                end
                popped++;
                if (popped >= nwords) begin
                    fin = 1;
                end
            end

            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (!fin && cyc > RUN_BUDGET) begin
                check("run_timeout", 32'(popped), 32'(nwords));
                break;
            end
        end

        start      = 1'b0;
        nt_valid   = 1'b0;
        word_ready = 1'b0;
        if (fin) begin
            check("bases_consumed",  32'(idx),        32'(len));
            check("done_pulse",      32'(done),       1);
            check("busy_after_done", 32'(busy),       0);
            check("ready_after_done", 32'(nt_ready),  0);
            check("empty_after_done", 32'(word_valid), 0);
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 0);
            check("idle_busy",      32'(busy), 0);
        end
    endtask

    initial begin
        vecs[0] = '{len: 2,  pattern: 3, w0: 32'h0000_0009, b0: 5'd2,  nwords: 1};
        vecs[1] = '{len: 16, pattern: 1, w0: 32'hE4E4_E4E4, b0: 5'd16, nwords: 1};
        vecs[2] = '{len: 5,  pattern: 2, w0: 32'h0000_03FF, b0: 5'd5,  nwords: 1};
        vecs[3] = '{len: 17, pattern: 1, w0: 32'hE4E4_E4E4, b0: 5'd16, nwords: 2};
        vecs[4] = '{len: 1,  pattern: 2, w0: 32'h0000_0003, b0: 5'd1,  nwords: 1};

        reset      = 1'b1;
        start      = 1'b0;
        seq_len    = '0;
        nt_in      = 2'b00;
        nt_valid   = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Zero-length start is ignored.
        @(negedge clk);
        start   = 1'b1;
        seq_len = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("zero_len_busy",  32'(busy),       0);
            check("zero_len_ready", 32'(nt_ready),   0);
            check("zero_len_valid", 32'(word_valid), 0);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset after 7 bases of a 20-base run discards everything.
        fill_bases(20, 0);
        start   = 1'b1;
        seq_len = SEQ_LEN_W'(20);
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        nt_valid   = 1'b1;
        word_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            nt_in = bases_q[i];
            @(posedge clk);
            @(negedge clk);
        end
        nt_valid   = 1'b0;
        word_ready = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("mid_reset");
        reset = 1'b0;

        // Directed table: the first entry is the post-reset C,G run.
        for (int v = 0; v < 5; v++) begin
            fill_bases(vecs[v].len, vecs[v].pattern);
            run_seq(vecs[v].len, 100, 100, 0, 0);
            check("tbl_nwords", 32'(got_q.size()), 32'(vecs[v].nwords));
            if (got_q.size() > 0) begin
                check("tbl_w0_data",  got_q[0].data,       vecs[v].w0);
                check("tbl_w0_bases", 32'(got_q[0].bases), 32'(vecs[v].b0));
            end
        end

        // 80 bases with the consumer stalled: intake stops after 64 bases,
        // then five words drain in order with last only on the fifth.
        fill_bases(80, 0);
        run_seq(80, 100, 100, 100, 0);
        check("stall_nwords", 32'(got_q.size()), 5);
        if (got_q.size() == 5) begin
            check("stall_w3_last",  32'(got_q[3].last),  0);
            check("stall_w4_last",  32'(got_q[4].last),  1);
            check("stall_w4_bases", 32'(got_q[4].bases), 16);
        end

        // Start pulse mid-collect with a different length is ignored, and
        // nt_valid stays high through the drain phase.
        fill_bases(37, 0);
        run_seq(37, 100, 50, 0, 1);
        check("restart_nwords", 32'(got_q.size()), 3);

        // Randomized runs against the model.
        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(1, 70);
            fill_bases(len, 0);
            run_seq(len, $urandom_range(50, 100), $urandom_range(30, 100), 0,
                    (len >= 8) && ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
